// File: rtl/vote_input_ctrl.sv
// Vote front-end: synchronizes and debounces four candidate buttons, then emits one
// single-cycle vote pulse per press with lockout. Optional macro VOTE_TOTAL_EN adds a vote total.
module vote_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LOCKOUT_CYCLES  = 64,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  input  logic       btn4,
  output logic       can1,
  output logic       can2,
  output logic       can3,
  output logic       can4,
  output logic       busy,
  output logic       invalid
`ifdef VOTE_TOTAL_EN
  ,
  output logic [7:0] total_votes,
  output logic       total_sat
`endif
);

  typedef enum logic [2:0] {IDLE, READY, PULSE, LOCKOUT, WAIT_REL} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

  logic [3:0]            sync1_q, sync1_d;
  logic [3:0]            sync2_q, sync2_d;
  logic [3:0]            level_q, level_d;
  logic [3:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic [3:0]            can_q, can_d;
  logic                  busy_q, busy_d;
  logic                  invalid_q, invalid_d;
  logic [2:0]            npress;
  logic                  quiet;

  always_comb begin
    sync1_d = {btn4, btn3, btn2, btn1};
    sync2_d = sync1_q;
  end

  // Counter tracks how long the synchronized sample has disagreed with the accepted level.
  always_comb begin
    level_d   = level_q;
    deb_cnt_d = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) level_d[i] = ~level_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    npress = 3'($countones(level_q));
    quiet  = (npress == 3'd0) && (sync1_q == '0) && (sync2_q == '0) && (deb_cnt_q == '0);
  end

  // In IDLE the lockout counter doubles as a one-cycle settle flag so that the reset
  // values of the synchronizers cannot be mistaken for released buttons.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    can_d      = '0;
    invalid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!quiet) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q != '0) begin
          lock_cnt_d = '0;
          state_d    = READY;
        end else begin
          lock_cnt_d = CNT_W'(1);
        end
      end
      READY: begin
        if (npress != 3'd0) begin
          if (mode) begin
            state_d = WAIT_REL;
          end else if (npress == 3'd1) begin
            can_d   = level_q;
            state_d = PULSE;
          end else begin
            invalid_d = 1'b1;
            state_d   = WAIT_REL;
          end
        end
      end
      PULSE: begin
        lock_cnt_d = LOCK_LAST;
        state_d    = LOCKOUT;
      end
      LOCKOUT: begin
        if (lock_cnt_q == '0) state_d = WAIT_REL;
        else                  lock_cnt_d = lock_cnt_q - 1'b1;
      end
      WAIT_REL: begin
        if (npress == 3'd0) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != READY);
  end

`ifdef VOTE_TOTAL_EN
  logic [7:0] total_q, total_d;

  always_comb begin
    total_d = total_q;
    if ((can_d != '0) && (total_q != 8'hFF)) total_d = total_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) total_q <= '0;
    else        total_q <= total_d;
  end

  assign total_votes = total_q;
  assign total_sat   = (total_q == 8'hFF);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      deb_cnt_q  <= '0;
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      can_q      <= '0;
      busy_q     <= 1'b1;
      invalid_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      can_q      <= can_d;
      busy_q     <= busy_d;
      invalid_q  <= invalid_d;
    end
  end

  assign {can4, can3, can2, can1} = can_q;
  assign busy    = busy_q;
  assign invalid = invalid_q;

endmodule
